jogador_automatico_exp3: RTL and testbench
==========================================

# jogador_automatico_exp3

Automatic player for the Experiência 3 memory game: drives the game's `iniciar` and `chaves` inputs with a fixed 16-entry one-hot sequence and judges the game's `pronto`/`acertou`/`errou` response. It can optionally inject one wrong play at a chosen position. It sits opposite `circuito_exp3` on the same board or in a bench, replacing the human at the switches. The block reports a pass/fail verdict so a full game can be self-checked in hardware.

## Interface

- `N_JOGADAS`, default 16: number of plays issued, 1..16.
- `HOLD`, default 1: cycles each play value is held on `chaves`, 1..255.
- `TIMEOUT`, default 1000: maximum wait for `pronto` after the last play, 1..65535.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `comecar`  in  1  start request; sampled only in OCIOSO or FIM.
- `injetar_erro`  in  1  inject a wrong play; captured on accepted start.
- `posicao_erro`  in  4  index of the wrong play; captured on accepted start.
- `pronto`  in  1  from game: game ended.
- `acertou`  in  1  from game: win.
- `errou`  in  1  from game: loss.
- `iniciar`  out  1  to game: start pulse.
- `chaves`  out  4  to game: play value; 0000 when not playing.
- `fim`  out  1  verdict valid.
- `sucesso`  out  1  game outcome matched expectation.
- `falha`  out  1  game outcome differed from expectation, or timeout.
- `timeout`  out  1  `pronto` never arrived.
- `db_jogada`  out  4  current or last play index.
- `db_estado`  out  4  state code.

## Operation

- Fixed ROM, indices 0..15: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- Play value at index k:
  - Normally ROM[k].
  - If injection is captured and k == posicao_erro, the value is ROM[k] rotated left by 1 (bit3→bit0). It is still one-hot and always wrong.
- States and codes:
  - OCIOSO (0): outputs 0. On `comecar`=1, capture `injetar_erro` and `posicao_erro`, clear k, go to PULSO.
  - PULSO (1): `iniciar`=1, `chaves`=0000, exactly one cycle. Go to JOGADA.
  - JOGADA (2): `chaves`=value(k) for HOLD cycles. At the end of the hold:
    - If k == N_JOGADAS-1, or (injection and k == posicao_erro), go to ESPERA.
    - Otherwise k += 1 and stay in JOGADA.
  - ESPERA (3): `chaves`=0000; the watchdog counts cycles.
    - `pronto`=1: register `acertou`/`errou`, go to FIM.
    - Watchdog reaches TIMEOUT: set timeout flag, go to FIM.
  - FIM (F): `fim`=1; `sucesso`/`falha`/`timeout` are held. `comecar`=1 restarts (same as OCIOSO start: clear verdict, go to PULSO).
- Early end: `pronto`=1 seen in JOGADA registers the result and goes to FIM immediately. Remaining plays are not issued.
- Expected outcome:
  - With injection active: `errou`=1 and `acertou`=0.
  - Without injection: `acertou`=1 and `errou`=0.
  - `sucesso` = registered outcome matches expectation and no timeout; `falha` = not `sucesso`.
  - An injection with posicao_erro ≥ N_JOGADAS is never reached; expectation stays "win".
- `comecar` is ignored in PULSO, JOGADA and ESPERA.
- Game inputs are assumed synchronous to `clock`; no synchronizers.

## Timing

- Reset (async) values: `iniciar`=0, `chaves`=0000, `fim`=0, `sucesso`=0, `falha`=0, `timeout`=0, `db_jogada`=0, `db_estado`=0; state OCIOSO.
- Reset asserted mid-game returns all outputs to reset values immediately. No resumption.
- All outputs are registered or decoded from registered state; they change only after rising edges.
- Start latency: `comecar` sampled at edge t; `iniciar`=1 during cycle t+1; first play value during t+2.
- Play k is on `chaves` during cycles t+2+k·HOLD … t+1+(k+1)·HOLD.
- Full game without injection: ESPERA entered 2+N_JOGADAS·HOLD cycles after start.
- `pronto` sampled in ESPERA at edge e gives `fim`=1 from e+1 onward.
- Timeout: `timeout`=`falha`=1 exactly TIMEOUT cycles after ESPERA entry.

## Test plan

- Game model wins after the 16th play: `comecar` pulse, HOLD=1 → `iniciar` for one cycle, then 0001, 0010, … 0100 on consecutive cycles. Model returns `pronto`=1, `acertou`=1 → `fim`=1, `sucesso`=1, `falha`=0, `db_jogada`=15.
- Injection at `posicao_erro`=3 → plays 0001, 0010, 0100, then 0001 (rotated 1000), then `chaves`=0000. Model returns `errou`=1 → `sucesso`=1. If the model returns `acertou` instead → `falha`=1.
- Model never raises `pronto`, TIMEOUT=20 → `timeout`=1, `falha`=1 exactly 20 cycles after the last play ends.
- `reset` pulse during play 5 → `chaves`=0000, `iniciar`=0 and `db_estado`=0 immediately; a later `comecar` restarts from play 0.
- `comecar` held high throughout → a single `iniciar` pulse per game. From FIM, a new `comecar` clears the verdict and starts a second game.
- HOLD=3 → each value present exactly 3 cycles. Early `pronto`+`errou` during play 2 without injection → FIM with `falha`=1, `db_jogada`=2.

Source files
------------

// File: rtl/jogador_automatico_exp3.sv
// jogador_automatico_exp3
// Automatic player for the Experiencia 3 memory game. It pulses `iniciar`,
// then drives a fixed 16-entry one-hot sequence on `chaves`. It can replace
// one play with a wrong value. It then judges the game's
// pronto/acertou/errou answer and reports a pass/fail verdict.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   comecar             start request (accepted in OCIOSO or FIM)
//   injetar_erro        inject one wrong play (captured on accepted start)
//   posicao_erro[3:0]   index of the wrong play (captured on accepted start)
//   pronto/acertou/errou game answer (end, win, loss)
//   iniciar             one-cycle start pulse to the game
//   chaves[3:0]         current play value, 0000 outside JOGADA
//   fim                 verdict valid
//   sucesso/falha       outcome matched / differed from expectation
//   timeout             `pronto` never arrived
//   db_jogada[3:0]      current or last play index
//   db_estado[3:0]      state code (0,1,2,3,F)
module jogador_automatico_exp3 #(
  parameter int N_JOGADAS = 16,
  parameter int HOLD      = 1,
  parameter int TIMEOUT   = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       comecar,
  input  logic       injetar_erro,
  input  logic [3:0] posicao_erro,
  input  logic       pronto,
  input  logic       acertou,
  input  logic       errou,
  output logic       iniciar,
  output logic [3:0] chaves,
  output logic       fim,
  output logic       sucesso,
  output logic       falha,
  output logic       timeout,
  output logic [3:0] db_jogada,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO = 4'h0,
    PULSO  = 4'h1,
    JOGADA = 4'h2,
    ESPERA = 4'h3,
    FIM    = 4'hF
  } estado_t;

  estado_t     estado_r, estado_prox_s;
  logic        inj_r;
  logic [3:0]  pos_r;
  logic [3:0]  k_r;
  logic [7:0]  hold_r;
  logic [15:0] wd_r;
  logic        sucesso_r, falha_r, timeout_r;

  logic        inicio_s, avanca_s, captura_s, estouro_s;
  logic        fim_hold_s, erro_alvo_s, ultima_s;
  logic        esperado_erro_s, resultado_ok_s;
  logic [3:0]  valor_s;

  // Fixed play sequence of the game.
  function automatic logic [3:0] rom_jogada(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_jogada = 4'b0001;
      4'd1:    rom_jogada = 4'b0010;
      4'd2:    rom_jogada = 4'b0100;
      4'd3:    rom_jogada = 4'b1000;
      4'd4:    rom_jogada = 4'b0100;
      4'd5:    rom_jogada = 4'b0010;
      4'd6:    rom_jogada = 4'b0001;
      4'd7:    rom_jogada = 4'b0001;
      4'd8:    rom_jogada = 4'b0010;
      4'd9:    rom_jogada = 4'b0010;
      4'd10:   rom_jogada = 4'b0100;
      4'd11:   rom_jogada = 4'b0100;
      4'd12:   rom_jogada = 4'b1000;
      4'd13:   rom_jogada = 4'b1000;
      4'd14:   rom_jogada = 4'b0001;
      4'd15:   rom_jogada = 4'b0100;
      default: rom_jogada = 4'b0000;
    endcase
  endfunction

  // Play decode: rotating a one-hot value left keeps it one-hot but always wrong.
  always_comb begin
    fim_hold_s      = (hold_r == 8'(HOLD - 1));
    erro_alvo_s     = inj_r && (k_r == pos_r);
    ultima_s        = (k_r == 4'(N_JOGADAS - 1)) || erro_alvo_s;
    // A position beyond the last play is never reached, so a win is expected.
    esperado_erro_s = inj_r && ({1'b0, pos_r} < 5'(N_JOGADAS));
    resultado_ok_s  = esperado_erro_s ? (errou && !acertou) : (acertou && !errou);
    if (erro_alvo_s) begin
      valor_s = {rom_jogada(k_r) [2:0], rom_jogada(k_r) [3]};
    end else begin
      valor_s = rom_jogada(k_r);
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r <= OCIOSO;
    end else begin
      estado_r <= estado_prox_s;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    estado_prox_s = estado_r;
    inicio_s      = 1'b0;
    avanca_s      = 1'b0;
    captura_s     = 1'b0;
    estouro_s     = 1'b0;
    case (estado_r)
      OCIOSO, FIM: begin
        if (comecar) begin
          estado_prox_s = PULSO;
          inicio_s      = 1'b1;
        end else begin
          estado_prox_s = estado_r;
        end
      end
      PULSO: begin
        estado_prox_s = JOGADA;
      end
      JOGADA: begin
        // An early answer from the game ends the run before the hold expires.
        if (pronto) begin
          estado_prox_s = FIM;
          captura_s     = 1'b1;
        end else if (fim_hold_s && ultima_s) begin
          estado_prox_s = ESPERA;
        end else if (fim_hold_s) begin
          avanca_s      = 1'b1;
        end else begin
          estado_prox_s = JOGADA;
        end
      end
      ESPERA: begin
        if (pronto) begin
          estado_prox_s = FIM;
          captura_s     = 1'b1;
        end else if (wd_r == 16'(TIMEOUT - 1)) begin
          estado_prox_s = FIM;
          estouro_s     = 1'b1;
        end else begin
          estado_prox_s = ESPERA;
        end
      end
      default: begin
        estado_prox_s = OCIOSO;
      end
    endcase
  end

  // Capture of start options, play index, hold/watchdog counters and verdict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inj_r     <= 1'b0;
      pos_r     <= 4'd0;
      k_r       <= 4'd0;
      hold_r    <= 8'd0;
      wd_r      <= 16'd0;
      sucesso_r <= 1'b0;
      falha_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      if (inicio_s) begin
        inj_r     <= injetar_erro;
        pos_r     <= posicao_erro;
        k_r       <= 4'd0;
        sucesso_r <= 1'b0;
        falha_r   <= 1'b0;
        timeout_r <= 1'b0;
      end else if (captura_s) begin
        sucesso_r <= resultado_ok_s;
        falha_r   <= !resultado_ok_s;
        timeout_r <= 1'b0;
      end else if (estouro_s) begin
        sucesso_r <= 1'b0;
        falha_r   <= 1'b1;
        timeout_r <= 1'b1;
      end else if (avanca_s) begin
        k_r <= k_r + 4'd1;
      end else begin
        k_r <= k_r;
      end
      if ((estado_r == JOGADA) && !fim_hold_s) begin
        hold_r <= hold_r + 8'd1;
      end else begin
        hold_r <= 8'd0;
      end
      if (estado_r == ESPERA) begin
        wd_r <= wd_r + 16'd1;
      end else begin
        wd_r <= 16'd0;
      end
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    iniciar = 1'b0;
    chaves  = 4'b0000;
    fim     = 1'b0;
    case (estado_r)
      PULSO:   iniciar = 1'b1;
      JOGADA:  chaves  = valor_s;
      FIM:     fim     = 1'b1;
      default: begin
        iniciar = 1'b0;
        chaves  = 4'b0000;
        fim     = 1'b0;
      end
    endcase
  end

  assign sucesso   = sucesso_r;
  assign falha     = falha_r;
  assign timeout   = timeout_r;
  assign db_jogada = k_r;
  assign db_estado = estado_r;

endmodule

// File: tb/tb_jogador_automatico_exp3.sv
// Testbench for jogador_automatico_exp3. Two instances: "a" (16 plays,
// HOLD=1, TIMEOUT=20) and "b" (12 plays, HOLD=3, TIMEOUT=20). A small game
// model answers the player, and the expected traces are built from the
// play rules.
module tb_jogador_automatico_exp3;

  logic       clock = 1'b0;
  logic       reset;
  logic       comecar_a, comecar_b;
  logic       injetar_erro;
  logic [3:0] posicao_erro;
  logic       pronto, acertou, errou;

  logic       iniciar_a, fim_a, sucesso_a, falha_a, timeout_a;
  logic [3:0] chaves_a, db_jogada_a, db_estado_a;
  logic       iniciar_b, fim_b, sucesso_b, falha_b, timeout_b;
  logic [3:0] chaves_b, db_jogada_b, db_estado_b;

  logic       sel_v;
  logic       o_iniciar, o_fim, o_sucesso, o_falha, o_timeout;
  logic [3:0] o_chaves, o_jogada, o_estado;

  logic [3:0] rom_tab [16];
  int checks = 0;
  int errors = 0;

  jogador_automatico_exp3 #(.N_JOGADAS(16), .HOLD(1), .TIMEOUT(20)) dut_a (
    .clock(clock), .reset(reset), .comecar(comecar_a),
    .injetar_erro(injetar_erro), .posicao_erro(posicao_erro),
    .pronto(pronto), .acertou(acertou), .errou(errou),
    .iniciar(iniciar_a), .chaves(chaves_a), .fim(fim_a),
    .sucesso(sucesso_a), .falha(falha_a), .timeout(timeout_a),
    .db_jogada(db_jogada_a), .db_estado(db_estado_a)
  );

  jogador_automatico_exp3 #(.N_JOGADAS(12), .HOLD(3), .TIMEOUT(20)) dut_b (
    .clock(clock), .reset(reset), .comecar(comecar_b),
    .injetar_erro(injetar_erro), .posicao_erro(posicao_erro),
    .pronto(pronto), .acertou(acertou), .errou(errou),
    .iniciar(iniciar_b), .chaves(chaves_b), .fim(fim_b),
    .sucesso(sucesso_b), .falha(falha_b), .timeout(timeout_b),
    .db_jogada(db_jogada_b), .db_estado(db_estado_b)
  );

  always #5 clock = ~clock;

  always_comb begin
    if (sel_v) begin
      o_iniciar = iniciar_b; o_fim = fim_b; o_sucesso = sucesso_b;
      o_falha = falha_b; o_timeout = timeout_b; o_chaves = chaves_b;
      o_jogada = db_jogada_b; o_estado = db_estado_b;
    end else begin
      o_iniciar = iniciar_a; o_fim = fim_a; o_sucesso = sucesso_a;
      o_falha = falha_a; o_timeout = timeout_a; o_chaves = chaves_a;
      o_jogada = db_jogada_a; o_estado = db_estado_a;
    end
  end

  task automatic verifica(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_comecar(input logic v);
    if (sel_v) comecar_b = v;
    else       comecar_a = v;
  endtask

  // modo: 0 honest game, 1 game reports the opposite, 2 silent game, 3 early loss at play k_cedo
  task automatic jogo(input logic sel, input bit ja, input bit segurar, input logic inj,
                      input logic [3:0] pos, input int modo, input int atraso, input int k_cedo);
    int n, hold, ultimo;
    logic [3:0] q[$];
    logic [3:0] v;
    bit errado, parou, to, rep_ac, rep_er, exp_err, ok;
    sel_v = sel;
    n    = sel ? 12 : 16;
    hold = sel ? 3 : 1;
    injetar_erro = inj;
    posicao_erro = pos;
    for (int k = 0; k < n; k++) begin
      v = rom_tab[k];
      if (inj && k == int'(pos)) v = {v[2:0], v[3]};
      q.push_back(v);
      if (inj && k == int'(pos)) break;
    end
    if (!ja) begin
      @(negedge clock);
      set_comecar(1'b1);
    end
    @(negedge clock);
    verifica("pulso_iniciar", 16'(o_iniciar), 16'd1);
    verifica("pulso_chaves", 16'(o_chaves), 16'd0);
    verifica("pulso_estado", 16'(o_estado), 16'h1);
    verifica("pulso_verdict", {13'd0, o_fim, o_sucesso, o_falha | o_timeout}, 16'd0);
    set_comecar(segurar);
    errado = 1'b0; parou = 1'b0; ultimo = 0; to = 1'b0; rep_ac = 1'b0; rep_er = 1'b0;
    for (int k = 0; k < q.size() && !parou; k++) begin
      for (int h = 0; h < hold && !parou; h++) begin
        @(negedge clock);
        verifica($sformatf("jogada%0d_chaves", k), 16'(o_chaves), 16'(q[k]));
        verifica($sformatf("jogada%0d_indice", k), 16'(o_jogada), 16'(k));
        verifica("jogada_estado", {11'd0, o_iniciar, o_estado}, 16'h2);
        if (o_chaves !== rom_tab[k]) errado = 1'b1;
        ultimo = k;
        if (modo == 3 && k == k_cedo) begin
          pronto = 1'b1; acertou = 1'b0; errou = 1'b1;
          rep_ac = 1'b0; rep_er = 1'b1; parou = 1'b1;
        end
      end
    end
    if (modo == 2) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        verifica("espera_estado", 16'(o_estado), 16'h3);
        verifica("espera_sem_timeout", {14'd0, o_timeout, o_fim}, 16'd0);
      end
      to = 1'b1;
    end else if (modo != 3) begin
      for (int i = 0; i <= atraso; i++) begin
        @(negedge clock);
        verifica("espera_estado", 16'(o_estado), 16'h3);
        verifica("espera_chaves", {11'd0, o_fim, o_chaves}, 16'd0);
      end
      rep_er = errado ^ (modo == 1);
      rep_ac = !rep_er;
      pronto = 1'b1; acertou = rep_ac; errou = rep_er;
    end
    @(negedge clock);
    pronto = 1'b0; acertou = 1'b0; errou = 1'b0;
    exp_err = inj && (int'(pos) < n);
    ok = !to && (exp_err ? (rep_er && !rep_ac) : (rep_ac && !rep_er));
    verifica("fim_estado", 16'(o_estado), 16'hF);
    verifica("fim_fim", 16'(o_fim), 16'd1);
    verifica("fim_sucesso", 16'(o_sucesso), 16'(ok));
    verifica("fim_falha", 16'(o_falha), 16'(!ok));
    verifica("fim_timeout", 16'(o_timeout), 16'(to));
    verifica("fim_jogada", 16'(o_jogada), 16'(ultimo));
    verifica("fim_chaves", {11'd0, o_iniciar, o_chaves}, 16'd0);
    if (!segurar) begin
      @(negedge clock);
      verifica("fim_mantido", {13'd0, o_fim, o_sucesso, o_falha}, {13'd0, 1'b1, ok, !ok});
    end
  endtask

  initial begin
    rom_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
    sel_v = 1'b0;
    reset = 1'b1; comecar_a = 1'b0; comecar_b = 1'b0;
    injetar_erro = 1'b0; posicao_erro = 4'd0;
    pronto = 1'b0; acertou = 1'b0; errou = 1'b0;
    #3;
    verifica("reset_a", {iniciar_a, chaves_a, fim_a, sucesso_a, falha_a, timeout_a, db_jogada_a}, 16'd0);
    verifica("reset_estado_a", 16'(db_estado_a), 16'd0);
    verifica("reset_b", {iniciar_b, chaves_b, fim_b, sucesso_b, falha_b, timeout_b, db_estado_b}, 16'd0);
    @(negedge clock);
    reset = 1'b0;

    // full win, injection at 3 (honest and lying game), timeout
    jogo(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 0);
    jogo(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 0, 2, 0);
    jogo(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1, 1, 0);
    jogo(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2, 0, 0);
    jogo(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 0, 0, 0);

    // reset in the middle of play 5
    sel_v = 1'b0;
    injetar_erro = 1'b0;
    @(negedge clock); comecar_a = 1'b1;
    @(negedge clock); comecar_a = 1'b0;
    repeat (6) @(negedge clock);
    verifica("antes_reset_chaves", 16'(chaves_a), 16'(rom_tab[5]));
    #2 reset = 1'b1;
    #1;
    verifica("reset_meio_saidas", {iniciar_a, chaves_a, fim_a, sucesso_a, falha_a, timeout_a}, 16'd0);
    verifica("reset_meio_estado", {db_jogada_a, db_estado_a}, 16'd0);
    @(negedge clock); reset = 1'b0;
    jogo(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0, 3, 0);

    // comecar held high: one pulse per game, then a chained second game
    jogo(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 0, 1, 0);
    jogo(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 0, 0, 0);

    // randomized games
    for (int g = 0; g < 8; g++) begin
      logic r_inj;
      logic [3:0] r_pos;
      r_inj = 1'($urandom_range(0, 1));
      r_pos = 4'($urandom_range(0, 15));
      jogo(1'b0, 1'b0, 1'b0, r_inj, r_pos, int'($urandom_range(0, 1)), int'($urandom_range(0, 12)), 0);
    end

    // HOLD=3 instance: full game, unreachable injection, early loss at play 2
    jogo(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 0);
    jogo(1'b1, 1'b0, 1'b0, 1'b1, 4'd13, 0, 1, 0);
    jogo(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 0, 0, 0);
    jogo(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
